alarm_scheduler: RTL and testbench



---
 rtl/alarm_scheduler.sv | 162 ++++++++++++++++
 tb/tb_alarm_scheduler.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alarm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : alarm_scheduler
// Brief    : Temperature zone classifier (hysteresis + debounce) with a timed
//            mute window; drives the buzzer command estado.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_scheduler #(
    parameter int TEMP_W      = 8,
    parameter int COLD_TH     = 18,
    parameter int HOT_TH      = 30,
    parameter int HYST        = 2,
    parameter int DEBOUNCE    = 4,
    parameter int MUTE_CYCLES = 500_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TEMP_W-1:0] temp,
    input  logic              temp_valid,
    input  logic              mute,
    output logic [1:0]        estado,
    output logic [1:0]        zona,
    output logic              muted
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int TW = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;

    localparam logic [CW-1:0]   c_debounce  = CW'(DEBOUNCE);
    localparam logic [TW-1:0]   c_mute_load = TW'(MUTE_CYCLES - 1);
    // Thresholds carry one extra bit so COLD_TH+HYST cannot wrap.
    localparam logic [TEMP_W:0] c_cold_th   = (TEMP_W+1)'(COLD_TH);
    localparam logic [TEMP_W:0] c_hot_th    = (TEMP_W+1)'(HOT_TH);
    localparam logic [TEMP_W:0] c_cold_hi   = (TEMP_W+1)'(COLD_TH + HYST);
    localparam logic [TEMP_W:0] c_hot_lo    = (TEMP_W+1)'((HOT_TH > HYST) ? (HOT_TH - HYST) : 0);

    localparam logic [1:0] c_frio   = 2'd0;
    localparam logic [1:0] c_normal = 2'd1;
    localparam logic [1:0] c_quente = 2'd2;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_MUTED = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_zona;
    logic [1:0]      w_zona_nxt;
    logic [1:0]      r_estado;
    logic [1:0]      w_estado_nxt;
    logic [1:0]      r_cand;
    logic [1:0]      w_cand_nxt;
    logic [1:0]      w_cand;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic            w_zone_chg;
    logic [TEMP_W:0] w_temp;

    assign w_temp = {1'b0, temp};

    // Candidate zone depends on the current zone (hysteresis).
    always_comb begin
        w_cand = r_zona;
        case (r_zona)
            c_frio: begin
                if (w_temp > c_hot_th)        w_cand = c_quente;
                else if (w_temp >= c_cold_hi) w_cand = c_normal;
                else                          w_cand = c_frio;
            end
            c_quente: begin
                if (w_temp < c_cold_th)       w_cand = c_frio;
                else if (w_temp <= c_hot_lo)  w_cand = c_normal;
                else                          w_cand = c_quente;
            end
            default: begin
                if (w_temp < c_cold_th)       w_cand = c_frio;
                else if (w_temp > c_hot_th)   w_cand = c_quente;
                else                          w_cand = c_normal;
            end
        endcase
    end

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_cand_nxt = r_cand;
        w_zona_nxt = r_zona;
        w_zone_chg = 1'b0;
        if (temp_valid) begin
            if (w_cand == r_zona) begin
                w_cnt_nxt = '0;
            end else if (w_cand == r_cand) begin
                w_cnt_nxt = r_cnt + 1'b1;
            end else begin
                w_cand_nxt = w_cand;
                w_cnt_nxt  = CW'(1);
            end
            if ((w_cand != r_zona) && (w_cnt_nxt == c_debounce)) begin
                w_zona_nxt = w_cand;
                w_cnt_nxt  = '0;
                w_zone_chg = 1'b1;
            end
        end
    end

    // A zone change always beats a mute request on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        case (r_state)
            S_IDLE: begin
                if (mute && (r_zona != c_normal) && !w_zone_chg) begin
                    w_state_nxt = S_MUTED;
                    w_timer_nxt = c_mute_load;
                end
            end
            S_MUTED: begin
                if (w_zone_chg) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end else if (mute) begin
                    w_timer_nxt = c_mute_load;
                end else if (r_timer == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
            end
        endcase
        w_estado_nxt = (w_state_nxt == S_MUTED) ? c_normal : w_zona_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_zona   <= c_normal;
            r_estado <= c_normal;
            r_cand   <= '0;
            r_cnt    <= '0;
            r_timer  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_zona   <= w_zona_nxt;
            r_estado <= w_estado_nxt;
            r_cand   <= w_cand_nxt;
            r_cnt    <= w_cnt_nxt;
            r_timer  <= w_timer_nxt;
        end
    end

    assign estado = r_estado;
    assign zona   = r_zona;
    assign muted  = (r_state == S_MUTED);

endmodule
`default_nettype wire

// File: tb/tb_alarm_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_scheduler
// Brief    : Directed self-checking bench for alarm_scheduler (MUTE_CYCLES=100).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_scheduler;

    logic       clk;
    logic       rst_n;
    logic [7:0] temp;
    logic       temp_valid;
    logic       mute;
    logic [1:0] estado;
    logic [1:0] zona;
    logic       muted;

    int n_checks = 0;
    int n_fail   = 0;

    alarm_scheduler #(
        .TEMP_W      (8),
        .COLD_TH     (18),
        .HOT_TH      (30),
        .HYST        (2),
        .DEBOUNCE    (4),
        .MUTE_CYCLES (100)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .temp       (temp),
        .temp_valid (temp_valid),
        .mute       (mute),
        .estado     (estado),
        .zona       (zona),
        .muted      (muted)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_out(input string tag, input int ez, input int ee, input int em);
        check({tag, ".zona"},   32'(zona),   32'(ez));
        check({tag, ".estado"}, 32'(estado), 32'(ee));
        check({tag, ".muted"},  32'(muted),  32'(em));
    endtask

    // One clock: drive on the falling edge, return 1 time unit after the rising edge.
    task automatic step(input logic v, input logic [7:0] t, input logic m);
        @(negedge clk);
        temp_valid = v;
        temp       = t;
        mute       = m;
        @(posedge clk);
        #1;
    endtask

    task automatic samples(input logic [7:0] t, input int n);
        for (int i = 0; i < n; i++) step(1'b1, t, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; temp = '0; temp_valid = 1'b0; mute = 1'b0;
        idle(3);
        check_out("reset", 1, 1, 0);
        rst_n = 1'b1;

        // Normal band stays silent
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'd25, 1'b0);
            check_out("normal25", 1, 1, 0);
        end
        step(1'b0, 8'd0, 1'b1);
        check_out("mute_in_normal", 1, 1, 0);

        // Hot debounce: change exactly at the 4th agreeing sample
        samples(8'd25, 1);
        samples(8'd35, 3);
        check_out("hot_3rd", 1, 1, 0);
        samples(8'd35, 1);
        check_out("hot_4th", 2, 2, 0);

        // Hysteresis while hot
        samples(8'd29, 4);
        check_out("hyst_29", 2, 2, 0);
        samples(8'd28, 3);
        check_out("hyst_28_3rd", 2, 2, 0);
        samples(8'd28, 1);
        check_out("hyst_28_4th", 1, 1, 0);

        // Interrupted streak does not change zone
        samples(8'd35, 2);
        samples(8'd25, 1);
        samples(8'd35, 1);
        check_out("interrupted", 1, 1, 0);

        // Cold, with gaps between samples
        samples(8'd10, 2);
        idle(3);
        samples(8'd10, 1);
        check_out("cold_gap_3rd", 1, 1, 0);
        samples(8'd10, 1);
        check_out("cold_4th", 0, 0, 0);
        samples(8'd19, 4);
        check_out("hyst_19", 0, 0, 0);
        samples(8'd20, 3);
        check_out("hyst_20_3rd", 0, 0, 0);
        samples(8'd20, 1);
        check_out("hyst_20_4th", 1, 1, 0);
        samples(8'd10, 4);
        check_out("cold_again", 0, 0, 0);

        // Mute window of 100 cycles
        step(1'b0, 8'd0, 1'b1);
        check_out("mute_edge", 0, 1, 1);
        idle(99);
        check_out("mute_e99", 0, 1, 1);
        idle(1);
        check_out("mute_e100", 0, 0, 0);

        // Reload at cycle 50 extends to 150
        step(1'b0, 8'd0, 1'b1);
        idle(49);
        step(1'b0, 8'd0, 1'b1);
        idle(50);
        check_out("ext_e100", 0, 1, 1);
        idle(49);
        check_out("ext_e149", 0, 1, 1);
        idle(1);
        check_out("ext_e150", 0, 0, 0);

        // Zone change cancels the window
        step(1'b0, 8'd0, 1'b1);
        samples(8'd40, 3);
        check_out("muted_hot_3rd", 0, 1, 1);
        samples(8'd40, 1);
        check_out("muted_hot_4th", 2, 2, 0);

        // Simultaneous zone change and mute
        samples(8'd10, 4);
        check_out("back_cold", 0, 0, 0);
        samples(8'd40, 3);
        step(1'b1, 8'd40, 1'b1);
        check_out("simul", 2, 2, 0);

        // Reset mid-window and mid-debounce
        step(1'b0, 8'd0, 1'b1);
        check_out("pre_rst_mute", 2, 1, 1);
        samples(8'd10, 2);
        check_out("pre_rst_partial", 2, 1, 1);
        rst_n = 1'b0;
        step(1'b0, 8'd0, 1'b0);
        rst_n = 1'b1;
        check_out("rst_mid", 1, 1, 0);
        samples(8'd10, 3);
        check_out("post_rst_3rd", 1, 1, 0);
        samples(8'd10, 1);
        check_out("post_rst_4th", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
